// File: rtl/coeff_loader.sv
// Writer side of the Toeplitz coefficient RAM: fills DEPTH words from a valid/ready
// stream, then holds sum_en high until sum_row reports completion.
module coeff_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              load_start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_adress,
  output logic [DATA_W-1:0] wr_data,
  output logic              sum_en,
  input  logic              sum_done,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  // One spare counter bit so DEPTH == 2**ADDR_W terminates without wrapping.
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LastWord = CntW'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait1,
    StRun
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                din_ready_q, din_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_adress_q, wr_adress_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                sum_en_q, sum_en_d;
  logic                busy_q, busy_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                xfer;

  assign xfer = din_valid & din_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_adress_d = wr_adress_q;
    wr_data_d   = wr_data_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_en_d     = 1'b1;
          wr_adress_d = cnt_q[ADDR_W-1:0];
          wr_data_d   = din;
          cnt_d       = cnt_q + CntW'(1);
          if (cnt_q == LastWord) begin
            state_d = StWait1;
          end
        end
      end
      StWait1: begin
        state_d = StRun;
      end
      StRun: begin
        if (sum_done) begin
          state_d     = StIdle;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Ready and busy follow the next state so they line up with the state register.
    din_ready_d = (state_d == StLoad);
    busy_d      = (state_d != StIdle);
    // sum_en lags entry into RUN by one cycle, giving the final write a full settle cycle.
    sum_en_d    = (state_q == StRun) && !sum_done;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      din_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_adress_q <= '0;
      wr_data_q   <= '0;
      sum_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_ready_q <= din_ready_d;
      wr_en_q     <= wr_en_d;
      wr_adress_q <= wr_adress_d;
      wr_data_q   <= wr_data_d;
      sum_en_q    <= sum_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign din_ready = din_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_adress = wr_adress_q;
  assign wr_data   = wr_data_q;
  assign sum_en    = sum_en_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Writer side of the Toeplitz coefficient RAM (128 x 32 block memory).
- `sum_row` only reads this RAM, over `adress`/`read_en`/`coeff`. This block fills it from a 32-bit valid/ready word stream.
- Once all DEPTH words are written, it asserts `sum_en` to start `sum_row`. It holds `sum_en` until `sum_row` reports completion, then returns to idle ready for the next coefficient frame.

Parameters:
- DATA_W, 32, coefficient word width; matches RAM `dina`/`douta`.
- ADDR_W, 7, RAM address width.
- DEPTH, 128, words per coefficient frame; DEPTH <= 2**ADDR_W.

Ports:
- `clk_in` in 1: single clock, shared with `sum_row` and the RAM.
- `rst` in 1: synchronous, active-high reset.
- `load_start` in 1: one-cycle request to begin loading a frame. Honoured only in IDLE.
- `din` in DATA_W: coefficient word.
- `din_valid` in 1: `din` valid.
- `din_ready` out 1: loader accepts `din` this cycle.
- `wr_en` out 1: RAM write enable (`ena`/`wea`).
- `wr_adress` out ADDR_W: RAM write address.
- `wr_data` out DATA_W: RAM write data.
- `sum_en` out 1: start/hold enable to `sum_row`.
- `sum_done` in 1: completion pulse from `sum_row` (its `write_en`).
- `busy` out 1: high in any state except IDLE.
- `frame_cnt` out 8: completed frames, wraps 255 -> 0.

Behaviour:
- All outputs are registered. Reset value of every output is 0. State resets to IDLE and the internal word counter to 0.
- A word transfer occurs on a rising edge where `din_valid & din_ready`.
- States:
  - IDLE:
    - `din_ready`=0, `sum_en`=0.
    - `load_start`=1 -> LOAD next cycle; word counter cleared to 0.
  - LOAD:
    - `din_ready`=1.
    - On each transfer, next cycle: `wr_en`=1, `wr_adress`=counter, `wr_data`=`din`; counter increments. Write latency is 1 cycle from transfer.
    - With no transfer, `wr_en`=0 next cycle. `wr_adress` and `wr_data` hold their last values.
    - On the transfer of word DEPTH-1, `din_ready` drops to 0 in the same registered update. No word beyond DEPTH is ever accepted; state -> WAIT1.
  - WAIT1:
    - One settle cycle so the final RAM write completes before `sum_row` reads.
    - `wr_en` is 1 this cycle (last word written) and is 0 afterwards.
    - Next state RUN.
  - RUN:
    - `sum_en`=1, asserted the cycle after WAIT1.
    - Held until `sum_done`=1 is sampled. Then `sum_en`=0 next cycle, `frame_cnt` increments, state -> IDLE.
- Boundary and priority rules:
  - `load_start` outside IDLE: ignored, no effect.
  - `sum_done` outside RUN: ignored; `frame_cnt` unchanged.
  - `sum_done` and `load_start` in the same cycle while in RUN: go to IDLE. `load_start` is not remembered; a new pulse is required in IDLE.
  - `din_valid` gaps during LOAD: the loader waits indefinitely. There is no timeout, and addresses are never skipped.
  - `rst` has priority over everything. Reset mid-LOAD or mid-RUN:
    - Next cycle `sum_en`=0, `wr_en`=0, `din_ready`=0, counter=0, state IDLE.
    - Partially written RAM contents are not cleared.
    - `frame_cnt` returns to 0.
  - Counter width is ADDR_W+1, so DEPTH=2**ADDR_W terminates without wrap ambiguity.
  - `wr_adress` never exceeds DEPTH-1.
- `busy` = (state != IDLE), registered.

Test Plan:
- Basic frame: reset 4 cycles.
  - Stimulus: pulse `load_start`, then stream `din`=0x0000_0000..0x0000_007F with `din_valid` held high.
  - Response: 128 writes, `wr_adress` 0..127 with `wr_data`=address. `din_ready` falls right after word 127. `sum_en` rises exactly 2 cycles after the last write cycle.
  - Then pulse `sum_done`: `sum_en`=0 next cycle and `frame_cnt`=1.
- Backpressure/gaps: same stream with `din_valid` toggling 1,0,0,1 per cycle.
  - Response: still exactly 128 writes, contiguous addresses 0..127, and `wr_en` low in gap cycles.
  - A 129th word (0xDEAD_BEEF) offered after 127 is not accepted (`din_ready`=0) and is never written.
- Ignored controls:
  - `sum_done` pulsed in IDLE and in LOAD: `frame_cnt` stays 0.
  - `load_start` pulsed in LOAD at word 50: addresses continue 51..127 without restart.
- Mid-operation reset:
  - `rst` during LOAD at word 64: next cycle `busy`=0, `din_ready`=0, `wr_en`=0.
  - A new `load_start` then restarts writing at `wr_adress`=0.
  - `rst` during RUN: `sum_en`=0 next cycle.
- Back-to-back frames with RAM model plus `sum_row`:
  - Stimulus: load frame A, then load frame B = A XOR 0xFFFF_FFFF.
  - Response: `frame_cnt` reaches 2. The RAM read through `read_en`/`adress` returns frame B words, and `final_result` matches the golden Toeplitz product for shift_row = 3072'b1010101010.
